domain_bringup_seq: RTL and testbench
=====================================

// Module: domain_bringup_seq
// PURPOSE
//   Sequences reset release and clock enable for NUM_DOMAINS domains, one domain at a time.
//   Domain k's reset deasserts RESET_TICKS ticks after its sequencing starts; its clock enable
//   asserts CLOCK_TICKS ticks after that. Timebase is a one-cycle tick pulse from the RTC
//   (synchronised upstream). Power-down runs in reverse order. Sits between the PMU request
//   and the per-domain delay_gen instances.
// PARAMETERS
//   NUM_DOMAINS  4  domains sequenced; legal range >= 1
//   RESET_TICKS  5  ticks from sequencing start to rst_o[k] release; legal range >= 1
//   CLOCK_TICKS  3  ticks between rst_o[k] release and en_o[k] set (up), and between en_o[k] clear and rst_o[k] set (down); >= 1
//   CNT_W        $clog2(max(RESET_TICKS,CLOCK_TICKS)+1)  tick counter width (derived)
//   IDX_W        max(1,$clog2(NUM_DOMAINS))              domain index width (derived)
// PORTS
//   clk_i      in   1            sole clock; all logic on rising edge
//   srst_i     in   1            synchronous reset, active-high
//   tick_i     in   1            RTC tick, one clk_i cycle wide
//   up_req_i   in   1            level: 1 = bring all domains up, 0 = take all down
//   rst_o      out  NUM_DOMAINS  per-domain reset, active-high, registered
//   en_o       out  NUM_DOMAINS  per-domain clock enable, registered
//   idx_o      out  IDX_W        domain currently being sequenced
//   busy_o     out  1            state not in {IDLE, UP}
//   up_o       out  1            state == UP (all domains out of reset and enabled)
// BEHAVIOUR
// - Reset (srst_i=1 at edge): state=IDLE, rst_o='1, en_o='0, idx_o=0, cnt=0, busy_o=0, up_o=0.
//   srst_i overrides all other inputs, including a tick in the same cycle. Applies mid-sequence.
// - States: IDLE, UP_RST (wait RESET_TICKS), UP_EN (wait CLOCK_TICKS), UP,
//   DN_WAIT (wait CLOCK_TICKS), DN_RST.
// - Tick counting: cnt is cleared on every state change. In UP_RST, UP_EN and DN_WAIT, each cycle
//   with tick_i=1 increments cnt. A tick sampled on a transition edge belongs to the old state.
//   Ticks in IDLE, UP and DN_RST are ignored.
// - IDLE and up_req_i=1 -> UP_RST with idx=0.
// - UP_RST: on the edge that samples the RESET_TICKS-th tick, clear rst_o[idx] and go to UP_EN.
// - UP_EN: on the edge that samples the CLOCK_TICKS-th tick, set en_o[idx].
//   If idx==NUM_DOMAINS-1, go to UP; otherwise idx++ and go to UP_RST.
// - UP and up_req_i=0 -> DN_WAIT at the current idx (NUM_DOMAINS-1); en_o[idx] clears on the same edge.
// - Abort: up_req_i=0 sampled in UP_RST or UP_EN -> DN_WAIT at the current idx; en_o[idx] cleared
//   on that edge. This is a no-op if en_o[idx] is already 0. Lower domains are then taken down normally.
// - DN_WAIT: on the edge that samples the CLOCK_TICKS-th tick, set rst_o[idx] and go to DN_RST.
// - DN_RST (1 cycle): if idx==0, go to IDLE. Otherwise idx--, clear en_o[idx], go to DN_WAIT.
// - up_req_i=1 during DN_* is ignored. Power-down always completes to IDLE; then IDLE restarts
//   the up sequence if up_req_i=1.
// - Invariant: en_o[k]=1 implies rst_o[k]=0. Only bit idx changes on any edge.
// - Outputs are registered; no combinational path from inputs to outputs.
// - Latency: IDLE to UP = NUM_DOMAINS*(RESET_TICKS+CLOCK_TICKS) ticks, plus 1 cycle.
// TESTING (NUM_DOMAINS=4, RESET_TICKS=5, CLOCK_TICKS=3, tick_i every 4 cycles unless stated)
// 1 srst_i=1 for 3 cycles, random up_req_i/tick_i -> rst_o=4'hF, en_o=0, idx_o=0, busy_o=0, up_o=0.
// 2 up_req_i=1 from IDLE -> rst_o F,E (5th tick); en_o 0,1 (8th tick); ... rst_o=0, en_o=F and
//   up_o=1 on the 32nd tick edge. Bench checks en_o[k] -> rst_o[k]==0 every cycle.
// 3 up_req_i=1, tick_i held 0 for 200 cycles -> rst_o=F, en_o=0, busy_o=1, idx_o=0 throughout.
// 4 From UP, up_req_i=0 -> en_o=7 next edge; rst_o=8 after 3 ticks; then en_o=3, ...;
//   IDLE with rst_o=F, en_o=0 after 12 ticks.
// 5 Abort: drop up_req_i in UP_EN at idx=1 (rst_o=C, en_o=1) -> rst_o=E after 3 ticks, en_o=0 one
//   cycle later, rst_o=F after 3 more ticks. Raising up_req_i mid-down has no effect until IDLE.
// 6 tick_i high on a transition edge, srst_i pulse during UP_EN at idx=2 -> tick counted once only;
//   reset restores rst_o=F, en_o=0 on the next edge, then the sequence restarts at idx 0.

Source files
------------

// File: rtl/domain_bringup_seq.sv
// Brings power domains out of reset one at a time on RTC ticks, then enables their clocks.
// Power-down runs the same steps in reverse order.

module domain_bringup_lane (
  input  logic clk_i,
  input  logic srst_i,
  input  logic sel,
  input  logic rst_set,
  input  logic rst_clr,
  input  logic en_set,
  input  logic en_clr,
  output logic rst_o,
  output logic en_o
);
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rst_o <= 1'b1;
      en_o  <= 1'b0;
    end else if (sel) begin
      if (rst_set)      rst_o <= 1'b1;
      else if (rst_clr) rst_o <= 1'b0;
      if (en_set)       en_o  <= 1'b1;
      else if (en_clr)  en_o  <= 1'b0;
    end
  end
endmodule

module domain_bringup_seq #(
  parameter  int NUM_DOMAINS = 4,
  parameter  int RESET_TICKS = 5,
  parameter  int CLOCK_TICKS = 3,
  localparam int MAX_TICKS   = (RESET_TICKS > CLOCK_TICKS) ? RESET_TICKS : CLOCK_TICKS,
  localparam int CNT_W       = $clog2(MAX_TICKS + 1),
  localparam int IDX_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   tick_i,
  input  logic                   up_req_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic [NUM_DOMAINS-1:0] en_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   busy_o,
  output logic                   up_o
);
  typedef enum logic [2:0] {IDLE, UP_RST, UP_EN, UP, DN_WAIT, DN_RST} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, ctl_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_set, rst_clr, en_set, en_clr;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ctl_idx = idx_q;
    rst_set = 1'b0;
    rst_clr = 1'b0;
    en_set  = 1'b0;
    en_clr  = 1'b0;
    case (state_q)
      IDLE: if (up_req_i) begin
        state_d = UP_RST;
        idx_d   = '0;
      end
      UP_RST: begin
        // Abort wins over a completing tick: the domain is still held in reset anyway.
        if (!up_req_i) begin
          state_d = DN_WAIT;
          en_clr  = 1'b1;
        end else if (tick_i) begin
          if (cnt_q == CNT_W'(RESET_TICKS - 1)) begin
            rst_clr = 1'b1;
            state_d = UP_EN;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UP_EN: begin
        if (!up_req_i) begin
          state_d = DN_WAIT;
          en_clr  = 1'b1;
        end else if (tick_i) begin
          if (cnt_q == CNT_W'(CLOCK_TICKS - 1)) begin
            en_set = 1'b1;
            if (idx_q == IDX_W'(NUM_DOMAINS - 1)) state_d = UP;
            else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = UP_RST;
            end
          end else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UP: if (!up_req_i) begin
        state_d = DN_WAIT;
        en_clr  = 1'b1;
      end
      DN_WAIT: if (tick_i) begin
        if (cnt_q == CNT_W'(CLOCK_TICKS - 1)) begin
          rst_set = 1'b1;
          state_d = DN_RST;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      DN_RST: begin
        if (idx_q == '0) state_d = IDLE;
        else begin
          // Clock of the next-lower domain stops on the same edge the index moves to it.
          idx_d   = idx_q - IDX_W'(1);
          ctl_idx = idx_d;
          en_clr  = 1'b1;
          state_d = DN_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_lane
    domain_bringup_lane u_lane (
      .clk_i   (clk_i),
      .srst_i  (srst_i),
      .sel     (ctl_idx == IDX_W'(k)),
      .rst_set (rst_set),
      .rst_clr (rst_clr),
      .en_set  (en_set),
      .en_clr  (en_clr),
      .rst_o   (rst_o[k]),
      .en_o    (en_o[k])
    );
  end

  assign idx_o  = idx_q;
  assign busy_o = (state_q != IDLE) && (state_q != UP);
  assign up_o   = (state_q == UP);
endmodule

// File: tb/tb_domain_bringup_seq.sv
// Directed bench for domain_bringup_seq: 4 domains, 5 reset ticks, 3 clock ticks,
// tick every 4 cycles while enabled.

module tb_domain_bringup_seq;
  logic       clk_i = 1'b0;
  logic       srst_i = 1'b1;
  logic       tick_i = 1'b0;
  logic       up_req_i = 1'b0;
  logic [3:0] rst_o, en_o;
  logic [1:0] idx_o;
  logic       busy_o, up_o;
  logic [11:0] obs, exp;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;
  int phase = 0;
  bit tick_auto = 1'b0;

  domain_bringup_seq #(.NUM_DOMAINS(4), .RESET_TICKS(5), .CLOCK_TICKS(3)) dut (
    .clk_i(clk_i), .srst_i(srst_i), .tick_i(tick_i), .up_req_i(up_req_i),
    .rst_o(rst_o), .en_o(en_o), .idx_o(idx_o), .busy_o(busy_o), .up_o(up_o)
  );

  always #5 clk_i = ~clk_i;
  assign obs = {rst_o, en_o, idx_o, busy_o, up_o};

  task automatic step();
    @(posedge clk_i);
    #1;
    if (tick_i) tick_cnt++;
    phase++;
    tick_i = tick_auto && (phase % 4 == 0);
  endtask

  task automatic start_ticks();
    phase = 0; tick_auto = 1'b1; tick_i = 1'b0;
  endtask

  task automatic stop_ticks();
    tick_auto = 1'b0; tick_i = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int target, guard;
    target = tick_cnt + n;
    guard = 0;
    while (tick_cnt < target && guard < 100) begin
      step();
      guard++;
    end
    checks++;
    if (tick_cnt < target) begin
      errors++;
      $display("FAIL wait_ticks: ticks=%0d required=%0d", tick_cnt, target);
    end
  endtask

  task automatic test_reset();
    srst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_req_i = 1'($urandom_range(0, 1));
      tick_i   = 1'($urandom_range(0, 1));
      step();
      exp = {4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset[%0d]: got %h exp %h", i, obs, exp); end
    end
    srst_i = 1'b0; up_req_i = 1'b0;
    stop_ticks();
    step();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_idle: got %h exp %h", obs, exp); end
  endtask

  task automatic test_bringup();
    int base, n;
    bit done;
    logic [3:0] e_rst, e_en;
    logic [1:0] e_idx;
    up_req_i = 1'b1;
    step();
    exp = {4'hF, 4'h0, 2'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL up_start: got %h exp %h", obs, exp); end
    start_ticks();
    base = tick_cnt;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      step();
      n = tick_cnt - base;
      for (int k = 0; k < 4; k++) begin
        e_rst[k] = !(n >= 8 * k + 5);
        e_en[k]  = (n >= 8 * k + 8);
      end
      e_idx = (n >= 24) ? 2'd3 : 2'(n / 8);
      exp = {e_rst, e_en, e_idx, (n < 32), (n >= 32)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL up_seq n=%0d: got %h exp %h", n, obs, exp); end
      checks++;
      if ((en_o & rst_o) !== 4'h0) begin
        errors++; $display("FAIL en_implies_rst_low: en=%h rst=%h", en_o, rst_o);
      end
      if (n >= 32) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL up_timeout: ticks=%0d required=32", tick_cnt - base); end
  endtask

  task automatic test_powerdown();
    logic [3:0] e_rst, e_en;
    stop_ticks();
    up_req_i = 1'b0;
    step();
    e_rst = 4'h0; e_en = 4'h7;
    exp = {e_rst, e_en, 2'd3, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL dn_first: got %h exp %h", obs, exp); end
    start_ticks();
    for (int k = 3; k >= 0; k--) begin
      wait_ticks(2);
      exp = {e_rst, e_en, 2'(k), 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL dn_hold[%0d]: got %h exp %h", k, obs, exp); end
      wait_ticks(1);
      e_rst[k] = 1'b1;
      exp = {e_rst, e_en, 2'(k), 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL dn_rst[%0d]: got %h exp %h", k, obs, exp); end
      step();
      if (k > 0) begin
        e_en[k-1] = 1'b0;
        exp = {e_rst, e_en, 2'(k - 1), 1'b1, 1'b0};
      end else exp = {4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL dn_next[%0d]: got %h exp %h", k, obs, exp); end
    end
  endtask

  task automatic test_no_ticks();
    stop_ticks();
    up_req_i = 1'b1;
    step();
    exp = {4'hF, 4'h0, 2'd0, 1'b1, 1'b0};
    for (int c = 0; c < 200; c++) begin
      step();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall[%0d]: got %h exp %h", c, obs, exp); end
    end
  endtask

  task automatic test_abort();
    srst_i = 1'b1; up_req_i = 1'b0;
    stop_ticks();
    step();
    srst_i = 1'b0; up_req_i = 1'b1;
    step();
    start_ticks();
    wait_ticks(14);
    exp = {4'hC, 4'h1, 2'd1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_pre: got %h exp %h", obs, exp); end
    up_req_i = 1'b0;
    step();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_edge: got %h exp %h", obs, exp); end
    up_req_i = 1'b1;
    wait_ticks(2);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_hold: got %h exp %h", obs, exp); end
    wait_ticks(1);
    exp = {4'hE, 4'h1, 2'd1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_rst1: got %h exp %h", obs, exp); end
    step();
    exp = {4'hE, 4'h0, 2'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_en0: got %h exp %h", obs, exp); end
    wait_ticks(3);
    exp = {4'hF, 4'h0, 2'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_rst0: got %h exp %h", obs, exp); end
    step();
    exp = {4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_idle: got %h exp %h", obs, exp); end
    step();
    exp = {4'hF, 4'h0, 2'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ab_restart: got %h exp %h", obs, exp); end
  endtask

  task automatic test_tick_edge_and_reset();
    srst_i = 1'b1; up_req_i = 1'b0;
    stop_ticks();
    step();
    srst_i = 1'b0; up_req_i = 1'b1;
    step();
    start_ticks();
    wait_ticks(5);
    exp = {4'hE, 4'h0, 2'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL te_rst0: got %h exp %h", obs, exp); end
    wait_ticks(2);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL te_once: got %h exp %h", obs, exp); end
    wait_ticks(1);
    exp = {4'hE, 4'h1, 2'd1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL te_en0: got %h exp %h", obs, exp); end
    wait_ticks(14);
    exp = {4'h8, 4'h3, 2'd2, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL te_idx2: got %h exp %h", obs, exp); end
    stop_ticks();
    tick_i = 1'b1; srst_i = 1'b1;
    step();
    exp = {4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL te_srst: got %h exp %h", obs, exp); end
    srst_i = 1'b0;
    step();
    exp = {4'hF, 4'h0, 2'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL te_restart: got %h exp %h", obs, exp); end
    start_ticks();
    wait_ticks(5);
    exp = {4'hE, 4'h0, 2'd0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL te_rerun: got %h exp %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_powerdown();
    test_no_ticks();
    test_abort();
    test_tick_edge_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
